// File: rtl/bp_stall_dump_pkg.sv
// Shared definitions for the stall-counter dump block: FSM states, header
// field layout and small sizing helpers.
package bp_stall_dump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_BODY    = 2'd2,
      ST_TRAILER = 2'd3
   } dump_state_e;

   // Header word layout: {seq, count, dropped}, dropped in the low byte
   localparam int HDR_SEQ_W    = 16;
   localparam int HDR_CNT_W    = 8;
   localparam int HDR_DROP_W   = 8;
   localparam int HDR_DROP_LSB = 0;
   localparam int HDR_CNT_LSB  = HDR_DROP_LSB + HDR_DROP_W;
   localparam int HDR_SEQ_LSB  = HDR_CNT_LSB + HDR_CNT_W;
   localparam int HDR_W        = HDR_SEQ_LSB + HDR_SEQ_W;

   // Index width that never collapses to zero for a single counter
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [HDR_W-1:0] make_header(
      input logic [HDR_SEQ_W-1:0]  seq,
      input logic [HDR_CNT_W-1:0]  cnt,
      input logic [HDR_DROP_W-1:0] drop
   );
      logic [HDR_W-1:0] h;
      h = '0;
      h[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
      h[HDR_CNT_LSB  +: HDR_CNT_W]  = cnt;
      h[HDR_DROP_LSB +: HDR_DROP_W] = drop;
      return h;
   endfunction

endpackage

// File: rtl/bp_stall_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module bp_stall_sat_counter #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] r_cnt;

   // Increment unless already saturated
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + width_p'(1);
      end
   end

   assign count_o = r_cnt;

endmodule

// File: rtl/bp_stall_snapshot_regs.sv
// Parallel-load register file holding the captured counters, with a
// combinational read port. Out-of-range indices read as zero.
module bp_stall_snapshot_regs #(
   parameter int num_counters_p = 24,
   parameter int width_p        = 32,
   parameter int idx_w_p        = 5
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic                              load_i,
   input  logic [num_counters_p*width_p-1:0] data_i,
   input  logic [idx_w_p-1:0]                rd_idx_i,
   output logic [width_p-1:0]                rd_data_o
);

   logic [num_counters_p-1:0][width_p-1:0] r_mem;

   // Capture every live counter at once on a load
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_mem <= '0;
      end else if (load_i) begin
         r_mem <= data_i;
      end
   end

   assign rd_data_o = (int'(rd_idx_i) < num_counters_p) ? r_mem[rd_idx_i] : '0;

endmodule

// File: rtl/bp_stall_counter_dump.sv
// Captures a snapshot of all stall counters and streams it out as
// header / body words / XOR trailer over a valid-ready interface.
module bp_stall_counter_dump
   import bp_stall_dump_pkg::*;
#(
   parameter int num_counters_p = 24,
   parameter int width_p        = 32
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_counters_p*width_p-1:0] counters_i,
   input  logic                              snapshot_i,
   output logic [width_p-1:0]                data_o,
   output logic                              v_o,
   input  logic                              ready_i,
   output logic                              busy_o,
   output logic [7:0]                        dropped_o
);

   localparam int                     IDX_W    = idx_width(num_counters_p);
   localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(num_counters_p - 1);
   localparam logic [HDR_CNT_W-1:0]   CNT8     = HDR_CNT_W'(num_counters_p);

   dump_state_e          r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [width_p-1:0]   r_acc;
   logic [width_p-1:0]   r_data;
   logic                 r_v;
   logic [15:0]          r_seq;

   logic                 w_load;
   logic                 w_drop;
   logic [IDX_W-1:0]     w_rd_idx;
   logic [width_p-1:0]   w_rd_data;
   logic [width_p-1:0]   w_acc_nxt;
   logic [HDR_W-1:0]     w_hdr32;
   logic [width_p-1:0]   w_hdr;
   logic [7:0]           w_dropped;

   assign w_load    = (r_state == ST_IDLE) & snapshot_i;
   assign w_drop    = (r_state != ST_IDLE) & snapshot_i;
   assign w_acc_nxt = r_acc ^ r_data;

   // The read port looks one word ahead so the next body word can be
   // registered on the handshake that retires the current one.
   assign w_rd_idx  = (r_state == ST_BODY) ? (r_idx + IDX_W'(1)) : '0;

   // Header is frozen at snapshot time, so later drops do not disturb it
   assign w_hdr32   = make_header(r_seq, CNT8, w_dropped);
   assign w_hdr     = width_p'(w_hdr32);

   bp_stall_snapshot_regs #(
      .num_counters_p (num_counters_p),
      .width_p        (width_p),
      .idx_w_p        (IDX_W)
   ) u_snap (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .load_i    (w_load),
      .data_i    (counters_i),
      .rd_idx_i  (w_rd_idx),
      .rd_data_o (w_rd_data)
   );

   bp_stall_sat_counter #(
      .width_p (8)
   ) u_dropped (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (w_drop),
      .count_o   (w_dropped)
   );

   // Dump FSM; v_o and data_o are registered and only move on a handshake
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_v     <= 1'b0;
         r_seq   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (snapshot_i) begin
                  r_state <= ST_HEADER;
                  r_idx   <= '0;
                  r_acc   <= '0;
                  r_v     <= 1'b1;
                  r_data  <= w_hdr;
               end
            end
            ST_HEADER: begin
               if (ready_i) begin
                  r_state <= ST_BODY;
                  r_idx   <= '0;
                  r_data  <= w_rd_data;
               end
            end
            ST_BODY: begin
               if (ready_i) begin
                  r_acc <= w_acc_nxt;
                  r_idx <= r_idx + IDX_W'(1);
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_TRAILER;
                     r_data  <= w_acc_nxt ^ {width_p{r_seq[0]}};
                  end else begin
                     r_data  <= w_rd_data;
                  end
               end
            end
            ST_TRAILER: begin
               if (ready_i) begin
                  r_state <= ST_IDLE;
                  r_seq   <= r_seq + 16'd1;
                  r_v     <= 1'b0;
                  r_data  <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign data_o    = r_data;
   assign v_o       = r_v;
   assign busy_o    = (r_state != ST_IDLE);
   assign dropped_o = w_dropped;

endmodule

// File: tb/tb_bp_stall_counter_dump.sv
// Bench for bp_stall_counter_dump (24 counters x 32 bits). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_bp_stall_counter_dump;

   localparam int N = 24;
   localparam int W = 32;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N*W-1:0]  counters_i;
   logic            snapshot_i;
   logic [W-1:0]    data_o;
   logic            v_o;
   logic            ready_i;
   logic            busy_o;
   logic [7:0]      dropped_o;

   int total = 0;
   int bad   = 0;

   // Reference state: what the dump stream should carry
   logic [15:0] m_seq;
   int          m_dropped;

   always #5 clk_i = ~clk_i;

   bp_stall_counter_dump #(.num_counters_p(N), .width_p(W)) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .counters_i (counters_i),
      .snapshot_i (snapshot_i),
      .data_o     (data_o),
      .v_o        (v_o),
      .ready_i    (ready_i),
      .busy_o     (busy_o),
      .dropped_o  (dropped_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // One complete dump from IDLE. The expected word list is built from the
   // captured values up front; each observed cycle must show its head word.
   task automatic do_dump(input int pat, input int rdy_pct, input bit scramble,
                          input int drops, input bit snap_trl,
                          output logic [31:0] hdr, output logic [31:0] trl,
                          output int nbusy);
      logic [31:0] cap[N];
      logic [31:0] q[$];
      logic [31:0] x;
      int          cyc;
      int          pos;
      int          drops_left;
      for (int k = 0; k < N; k++) begin
         case (pat)
            0:       cap[k] = 32'(k + 1);
            1:       cap[k] = 32'hFFFF_FFFF;
            2:       cap[k] = 32'(k) * 32'h0101_0101;
            default: cap[k] = $urandom();
         endcase
         counters_i[k*W +: W] = cap[k];
      end
      x = '0;
      q = {};
      q.push_back({m_seq, 8'd24, 8'(m_dropped)});
      for (int k = 0; k < N; k++) begin
         q.push_back(cap[k]);
         x ^= cap[k];
      end
      q.push_back(x ^ {32{m_seq[0]}});

      chk("idle_v", 32'(v_o), 32'd0);
      chk("idle_data", data_o, 32'd0);
      snapshot_i = 1'b1;
      ready_i    = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      snapshot_i = 1'b0;
      hdr = '0; trl = '0; nbusy = 0; cyc = 0; pos = 0; drops_left = drops;
      while (q.size() > 0) begin
         if (cyc >= 5000) begin
            total++; bad++;
            $display("FAIL dump_timeout words_left=%0d expected=0", q.size());
            break;
         end
         chk("v_o", 32'(v_o), 32'd1);
         chk("busy_o", 32'(busy_o), 32'd1);
         chk("data_o", data_o, q[0]);
         chk("dropped_o", 32'(dropped_o), 32'(m_dropped));
         if (busy_o) nbusy++;
         if (pos == 0)      hdr = data_o;
         if (q.size() == 1) trl = data_o;
         if (scramble && pos >= 2) counters_i = '1;
         snapshot_i = 1'b0;
         if (drops_left > 0) begin
            ready_i    = 1'b0;
            snapshot_i = 1'b1;
            drops_left--;
         end else begin
            ready_i = ($urandom_range(0, 99) < rdy_pct);
         end
         if (snap_trl && q.size() == 1 && ready_i) snapshot_i = 1'b1;
         if (snapshot_i && m_dropped < 255) m_dropped++;
         @(negedge clk_i);
         cyc++;
         if (ready_i) begin
            void'(q.pop_front());
            pos++;
         end
      end
      snapshot_i = 1'b0;
      ready_i    = 1'b0;
      chk("end_v", 32'(v_o), 32'd0);
      chk("end_busy", 32'(busy_o), 32'd0);
      chk("end_data", data_o, 32'd0);
      chk("end_dropped", 32'(dropped_o), 32'(m_dropped));
      m_seq = m_seq + 16'd1;
   endtask

   typedef struct {
      int          pat;
      int          rdy;
      bit          scr;
      int          drops;
      logic [31:0] hdr;
      logic [31:0] trl;
      int          busy;   // 0: not checked
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [31:0] hdr, trl;
      int          nb;

      #1_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] hdr, trl;
      int          nb;

      tbl[0] = '{0, 100, 1'b0, 0,   32'h0000_1800, 32'h0000_0018, 26};
      tbl[1] = '{0, 50,  1'b1, 0,   32'h0001_1800, 32'hFFFF_FFE7, 0};
      tbl[2] = '{1, 50,  1'b0, 0,   32'h0002_1800, 32'h0000_0000, 0};
      tbl[3] = '{2, 100, 1'b0, 0,   32'h0003_1800, 32'hFFFF_FFFF, 26};
      tbl[4] = '{0, 100, 1'b0, 300, 32'h0004_1800, 32'h0000_0018, 0};
      tbl[5] = '{0, 100, 1'b0, 0,   32'h0005_18FF, 32'hFFFF_FFE7, 26};

      reset_n_i  = 1'b0;
      counters_i = '0;
      snapshot_i = 1'b0;
      ready_i    = 1'b0;
      m_seq      = '0;
      m_dropped  = 0;

      @(negedge clk_i);
      chk("rst_v", 32'(v_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_dropped", 32'(dropped_o), 32'd0);
      // Release and request in the very first cycle out of reset
      reset_n_i = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_dump(tbl[i].pat, tbl[i].rdy, tbl[i].scr, tbl[i].drops, 1'b0, hdr, trl, nb);
         chk($sformatf("tbl%0d_hdr", i), hdr, tbl[i].hdr);
         chk($sformatf("tbl%0d_trl", i), trl, tbl[i].trl);
         if (tbl[i].busy != 0) chk($sformatf("tbl%0d_busy", i), 32'(nb), 32'(tbl[i].busy));
      end
      chk("dropped_sat", 32'(dropped_o), 32'd255);

      // Abort a dump with reset while body word 10 is on the bus
      for (int k = 0; k < N; k++) counters_i[k*W +: W] = 32'(k + 1);
      snapshot_i = 1'b1;
      ready_i    = 1'b1;
      @(negedge clk_i);
      snapshot_i = 1'b0;
      repeat (11) @(negedge clk_i);
      chk("mid_body10", data_o, 32'd11);
      #2 reset_n_i = 1'b0;
      #1;
      chk("async_v", 32'(v_o), 32'd0);
      chk("async_data", data_o, 32'd0);
      chk("async_busy", 32'(busy_o), 32'd0);
      chk("async_dropped", 32'(dropped_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      ready_i   = 1'b1;
      m_seq     = '0;
      m_dropped = 0;
      repeat (3) begin
         @(negedge clk_i);
         chk("post_rst_v", 32'(v_o), 32'd0);
      end
      ready_i = 1'b0;

      // Snapshot during the trailer handshake is dropped, no dump follows
      do_dump(0, 100, 1'b0, 0, 1'b1, hdr, trl, nb);
      chk("post_rst_hdr", hdr, 32'h0000_1800);
      repeat (3) begin
         @(negedge clk_i);
         chk("no_restart_v", 32'(v_o), 32'd0);
         chk("no_restart_busy", 32'(busy_o), 32'd0);
      end
      chk("trl_drop", 32'(dropped_o), 32'd1);
      do_dump(0, 100, 1'b0, 0, 1'b0, hdr, trl, nb);
      chk("next_hdr", hdr, 32'h0001_1801);

      // Random counters, backpressure and stray snapshot pulses
      for (int r = 0; r < 6; r++) begin
         do_dump(3, $urandom_range(30, 100), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), hdr, trl, nb);
         if ($urandom_range(0, 1) == 1) @(negedge clk_i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bp_stall_counter_dump.md
BP_STALL_COUNTER_DUMP -- requirements
Module: bp_stall_counter_dump

Interface
REQ-001 Parameter num_counters_p, default 24, is the number of stall counters captured per snapshot (1..255).
REQ-002 Parameter width_p, default 32, is the width of each counter and of the output word (>= 24).
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 counters_i  input  num_counters_p*width_p  flattened live stall counters; counter k occupies bits [k*width_p +: width_p].
REQ-006 snapshot_i  input  1  single-cycle request to capture and dump all counters.
REQ-007 data_o  output  width_p  output word.
REQ-008 v_o  output  1  data_o valid.
REQ-009 ready_i  input  1  consumer accepts data_o when v_o & ready_i.
REQ-010 busy_o  output  1  high whenever the FSM is not IDLE.
REQ-011 dropped_o  output  8  saturating count of snapshot requests ignored while busy.

Function
REQ-012 FSM states: IDLE, HEADER, BODY, TRAILER.
REQ-013 IDLE: when snapshot_i=1, the block shall copy all counters_i into the snapshot register array on that edge, clear the XOR accumulator and the index, and go to HEADER.
REQ-014 HEADER: the block shall drive v_o=1 with data_o = {seq[15:0], num_counters_p[7:0], dropped[7:0]}, zero-extended in the upper width_p-32 bits when width_p>32; when width_p<32, seq shall be truncated to width_p-16 bits.
REQ-015 HEADER: on handshake the block shall go to BODY with index=0.
REQ-016 BODY: the block shall drive v_o=1 with data_o = snapshot[index].
REQ-017 BODY: on each handshake the block shall XOR data_o into the accumulator and increment index.
REQ-018 BODY: on the handshake where index = num_counters_p-1, the block shall go to TRAILER.
REQ-019 TRAILER: the block shall drive v_o=1 with data_o = accumulator XOR {width_p{seq[0]}}.
REQ-020 TRAILER: on handshake the block shall increment seq (16-bit, wrapping 0xFFFF->0) and return to IDLE.
REQ-021 A dump shall be exactly num_counters_p+2 words. v_o shall be registered, and data_o shall be stable while v_o & ~ready_i.
REQ-022 Minimum latency: snapshot_i at cycle t gives the header valid at t+1. With ready_i held high, the trailer is accepted at t+num_counters_p+2, and the next snapshot is accepted no earlier than t+num_counters_p+3.
REQ-023 snapshot_i in any non-IDLE state, including the TRAILER-handshake cycle, shall be ignored and shall increment dropped; dropped saturates at 255.
REQ-024 Live counters_i changes after capture shall not affect the dump in progress.
REQ-025 In IDLE, v_o shall be 0 and data_o shall be 0.

Reset
REQ-026 reset_n_i=0 shall asynchronously force state=IDLE, v_o=0, data_o=0, busy_o=0, seq=0, dropped=0, index=0, accumulator=0 and the snapshot array to 0.
REQ-027 Reset asserted mid-dump shall abort the dump; after deassertion no partial words shall be emitted, and the first new dump shall carry seq=0.
REQ-028 snapshot_i in the first cycle after reset deassertion shall be honoured.

Structure
REQ-029 The FSM state enum and the header field widths/offsets (seq 16, count 8, dropped 8) shall reside in a shared package, bp_stall_dump_pkg.
REQ-030 The snapshot array shall be a sub-module, bp_stall_snapshot_regs: a parallel-load register file with a combinational read port indexed by a $clog2(num_counters_p)-bit index.
REQ-031 The dropped counter shall be a saturating counter instance; no other sub-modules.

Verification (num_counters_p=24, width_p=32)
REQ-032 Counters k=k+1, snapshot pulse, ready_i=1 -> header 0x0000_1800, words 1..24, then trailer 0x0000_0018 (XOR 1..24 = 24, seq[0]=0); busy_o high for 26 cycles.
REQ-033 Second dump, counters changed to 0xFFFF_FFFF during BODY -> header 0x0001_1800, body equals the values captured at the snapshot, trailer = XOR of those values ^ 0xFFFF_FFFF.
REQ-034 ready_i toggling randomly 50% -> data_o is stable under backpressure and the same 26-word sequence as the ready_i=1 case is emitted.
REQ-035 300 snapshot pulses issued while busy -> dropped_o=255 (saturated), and the next header's low byte is 0xFF.
REQ-036 reset_n_i pulsed low at BODY index 10 -> v_o=0 immediately (asynchronous); the next dump's header is 0x0000_1800.
REQ-037 snapshot_i asserted in the trailer-handshake cycle -> dropped increments by 1, and no new dump starts until snapshot_i is pulsed again in IDLE.
